// File: rtl/filter_border_mask_pkg.sv
// Shared definitions for the filter output masking stage.
// State encoding, widths, config bundle and the SKIP helper.
package filter_border_mask_pkg;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_FILL = 3'd1;
   localparam logic [2:0] ST_RUN  = 3'd2;
   localparam logic [2:0] ST_DONE = 3'd3;
   localparam logic [2:0] ST_ERR  = 3'd4;

   localparam int MAX_WIDTH  = 1024;
   localparam int MAX_HEIGHT = 65535;
   localparam int X_W        = 11;
   localparam int Y_W        = 16;
   localparam int SKIP_W     = 20;
   localparam int D_W        = 9;

   typedef struct packed {
      logic [X_W-1:0]    w_m1;
      logic [Y_W-1:0]    h_m1;
      logic [X_W-1:0]    w_r;
      logic [Y_W-1:0]    h_r;
      logic [SKIP_W-1:0] skip;
   } cfg_t;

   // Cycles from frame start until the first real filter result appears.
   function automatic logic [SKIP_W-1:0] calc_skip(
      input logic [X_W-1:0] w,
      input int             r,
      input int             lat
   );
      int t;
      t = r * int'(w) + r + 1 + lat;
      return t[SKIP_W-1:0];
   endfunction

endpackage

// File: rtl/filter_border_mask_pos_counter.sv
// Raster position counter for the masking stage.
// x wraps at w_m1, y advances on each wrap.
module filter_border_mask_pos_counter
   import filter_border_mask_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   input  logic           clr,
   input  logic           en,
   input  logic [X_W-1:0] w_m1,
   input  logic [Y_W-1:0] h_m1,
   output logic [X_W-1:0] x,
   output logic [Y_W-1:0] y,
   output logic           last_x,
   output logic           last_xy
);

   assign last_x  = (x == w_m1);
   assign last_xy = last_x && (y == h_m1);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         x <= '0;
         y <= '0;
      end else if (en) begin
         if (last_x) begin
            x <= '0;
            y <= y + Y_W'(1);
         end else begin
            x <= x + X_W'(1);
         end
      end
   end

endmodule

// File: rtl/filter_border_mask.sv
// Output stage after filter_unit: tracks pixel position, zeroes the
// border, drops pipeline fill-up data and frames the stream.
module filter_border_mask
   import filter_border_mask_pkg::*;
#(
   parameter int Ope_Size   = 3,
   parameter int Op_Latency = 2,
   parameter int Max_Width  = MAX_WIDTH
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           reflesh,
   input  logic [D_W-1:0] data_in,
   input  logic [31:0]    image_width,
   input  logic [31:0]    image_height,
   output logic [D_W-1:0] data_out,
   output logic           out_valid,
   output logic           out_eol,
   output logic           out_eof,
   output logic           busy,
   output logic           cfg_err
);

   localparam int R = Ope_Size >> 1;
   localparam logic [X_W-1:0] R_X = X_W'(R);
   localparam logic [Y_W-1:0] R_Y = Y_W'(R);

   logic [2:0]        state;
   cfg_t              cfg;
   cfg_t              cfg_new;
   logic [SKIP_W-1:0] skip_cnt;
   logic              legal;
   logic [X_W-1:0]    x;
   logic [Y_W-1:0]    y;
   logic              last_x;
   logic              last_xy;
   logic              border;
   logic              run;

   assign legal = (image_width  >= 32'(Ope_Size))
               && (image_width  <= 32'(Max_Width))
               && (image_height >= 32'(Ope_Size))
               && (image_height <= 32'(MAX_HEIGHT));

   // Derived limits are built from the raw inputs so they land in the
   // config register on the same clk as W/H themselves.
   always_comb begin
      cfg_new.w_m1 = image_width[X_W-1:0] - X_W'(1);
      cfg_new.h_m1 = image_height[Y_W-1:0] - Y_W'(1);
      cfg_new.w_r  = image_width[X_W-1:0] - R_X;
      cfg_new.h_r  = image_height[Y_W-1:0] - R_Y;
      cfg_new.skip = calc_skip(image_width[X_W-1:0], R, Op_Latency);
   end

   assign run  = (state == ST_RUN);
   assign busy = (state == ST_FILL) || run;

   assign border = (x < R_X) || (x >= cfg.w_r)
                || (y < R_Y) || (y >= cfg.h_r);

   filter_border_mask_pos_counter u_pos (
      .clk     (clk),
      .rst     (rst),
      .clr     (!run),
      .en      (run),
      .w_m1    (cfg.w_m1),
      .h_m1    (cfg.h_m1),
      .x       (x),
      .y       (y),
      .last_x  (last_x),
      .last_xy (last_xy)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         cfg       <= '0;
         skip_cnt  <= '0;
         cfg_err   <= 1'b0;
         data_out  <= '0;
         out_valid <= 1'b0;
         out_eol   <= 1'b0;
         out_eof   <= 1'b0;
      end else if (reflesh) begin
         cfg       <= cfg_new;
         skip_cnt  <= '0;
         state     <= legal ? ST_FILL : ST_ERR;
         cfg_err   <= !legal;
         data_out  <= '0;
         out_valid <= 1'b0;
         out_eol   <= 1'b0;
         out_eof   <= 1'b0;
      end else begin
         data_out  <= '0;
         out_valid <= 1'b0;
         out_eol   <= 1'b0;
         out_eof   <= 1'b0;
         case (state)
            ST_FILL: begin
               if (skip_cnt == cfg.skip - SKIP_W'(1)) begin
                  state    <= ST_RUN;
                  skip_cnt <= '0;
               end else begin
                  skip_cnt <= skip_cnt + SKIP_W'(1);
               end
            end
            ST_RUN: begin
               out_valid <= 1'b1;
               data_out  <= border ? '0 : data_in;
               out_eol   <= last_x;
               out_eof   <= last_xy;
               if (last_xy) state <= ST_DONE;
            end
            default: state <= state;
         endcase
      end
   end

endmodule

// File: tb/tb_filter_border_mask.sv
// Directed self-checking bench for filter_border_mask.
// Frames are scored against a raster/border model built from W, H, SKIP.
module tb_filter_border_mask;

   logic        clk = 1'b0;
   logic        rst;
   logic        reflesh;
   logic [8:0]  data_in;
   logic [31:0] image_width;
   logic [31:0] image_height;
   logic [8:0]  data_out;
   logic        out_valid;
   logic        out_eol;
   logic        out_eof;
   logic        busy;
   logic        cfg_err;

   int total = 0;
   int bad   = 0;

   int first_lbl, n_valid, n_zero, n_eol, n_eof, eof_lbl;
   int data_bad, eol_bad, eof_bad, idle_bad;
   logic [8:0] pix32;

   filter_border_mask dut (
      .clk          (clk),
      .rst          (rst),
      .reflesh      (reflesh),
      .data_in      (data_in),
      .image_width  (image_width),
      .image_height (image_height),
      .data_out     (data_out),
      .out_valid    (out_valid),
      .out_eol      (out_eol),
      .out_eof      (out_eof),
      .busy         (busy),
      .cfg_err      (cfg_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Label k = outputs seen during the cycle after clk edge k-1,
   // where edge 0 is the first clk after the reflesh edge.
   task automatic run_frame(input int w, input int h,
                            input bit start, input int budget);
      int skip, p, x, y;
      bit brd;
      logic [7:0] lo;
      logic [8:0] exp;
      skip = w + 1 + 1 + 2;
      first_lbl = -1; eof_lbl = -1;
      n_valid = 0; n_zero = 0; n_eol = 0; n_eof = 0;
      data_bad = 0; eol_bad = 0; eof_bad = 0; idle_bad = 0;
      pix32 = '0;
      if (start) begin
         @(negedge clk);
         image_width  = w;
         image_height = h;
         reflesh      = 1'b1;
         @(posedge clk);
      end
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         reflesh = 1'b0;
         if (out_valid) begin
            p   = n_valid;
            x   = p % w;
            y   = p / w;
            brd = (x < 1) || (x >= w - 1) || (y < 1) || (y >= h - 1);
            lo  = 8'(skip + p);
            exp = brd ? 9'h000 : {1'b1, lo};
            if (data_out !== exp) data_bad++;
            if (data_out == 9'h000) n_zero++;
            if (out_eol !== (x == w - 1)) eol_bad++;
            if (out_eof !== (x == w - 1 && y == h - 1)) eof_bad++;
            if (out_eol) n_eol++;
            if (out_eof) begin
               n_eof++;
               eof_lbl = k;
            end
            if (x == 3 && y == 2) pix32 = data_out;
            if (first_lbl < 0) first_lbl = k;
            n_valid++;
         end else if (data_out != 9'h000 || out_eol || out_eof) begin
            idle_bad++;
         end
         if (eof_lbl >= 0 && k >= eof_lbl + 3) break;
         data_in = {1'b1, 8'(k)};
         @(posedge clk);
      end
   endtask

   task automatic bad_cfg(input int w, input int h, input string tag);
      int nv, nb;
      nv = 0; nb = 0;
      @(negedge clk);
      image_width  = w;
      image_height = h;
      reflesh      = 1'b1;
      @(posedge clk);
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         reflesh = 1'b0;
         if (out_valid) nv++;
         if (busy) nb++;
         @(posedge clk);
      end
      #1;
      check({tag, "_cfg_err"}, 32'(cfg_err), 1);
      check({tag, "_valid"}, nv, 0);
      check({tag, "_busy"}, nb, 0);
   endtask

   initial begin
      int nv, nb, ne;
      rst = 1'b1; reflesh = 1'b0; data_in = '0;
      image_width = 8; image_height = 6;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_valid", 32'(out_valid), 0);
      check("rst_data", 32'(data_out), 0);
      check("rst_eol_eof", 32'({out_eol, out_eof}), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_cfg_err", 32'(cfg_err), 0);
      rst = 1'b0;

      run_frame(8, 6, 1'b1, 200);
      check("f8_first", first_lbl, 13);
      check("f8_nvalid", n_valid, 48);
      check("f8_nzero", n_zero, 8 * 6 - 6 * 4);
      check("f8_neol", n_eol, 6);
      check("f8_eol_pos", eol_bad, 0);
      check("f8_neof", n_eof, 1);
      check("f8_eof_pos", eof_bad, 0);
      check("f8_eof_lbl", eof_lbl, 12 + 47 + 1);
      check("f8_data", data_bad, 0);
      check("f8_pix32", 32'(pix32), 32'h11F);
      check("f8_idle", idle_bad, 0);
      check("f8_done_busy", 32'(busy), 0);

      bad_cfg(2, 6, "w2");
      bad_cfg(1025, 6, "w1025");
      bad_cfg(8, 0, "h0");

      // legal restart, then abort at the 20th RUN cycle
      @(negedge clk);
      image_width = 8; image_height = 6; reflesh = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reflesh = 1'b0;
      check("ok_cfg_err", 32'(cfg_err), 0);
      check("ok_busy", 32'(busy), 1);
      data_in = {1'b1, 8'd0};
      @(posedge clk);
      nv = 0; ne = 0;
      for (int k = 1; k <= 31; k++) begin
         @(negedge clk);
         if (out_valid) nv++;
         if (out_eof) ne++;
         data_in = {1'b1, 8'(k)};
         if (k == 31) reflesh = 1'b1;
         @(posedge clk);
      end
      #1;
      check("ab_pre_valid", nv, 19);
      check("ab_valid", 32'(out_valid), 0);
      check("ab_eof", ne + 32'(out_eof), 0);
      run_frame(8, 6, 1'b0, 200);
      check("ab_first", first_lbl, 13);
      check("ab_nvalid", n_valid, 48);
      check("ab_neof", n_eof, 1);
      check("ab_data", data_bad, 0);

      // rst and reflesh together while running
      @(negedge clk);
      image_width = 8; image_height = 6; reflesh = 1'b1;
      @(posedge clk);
      for (int k = 0; k <= 20; k++) begin
         @(negedge clk);
         reflesh = 1'b0;
         data_in = {1'b1, 8'(k)};
         if (k == 20) begin
            rst = 1'b1;
            reflesh = 1'b1;
         end
         @(posedge clk);
      end
      #1;
      check("rr_valid", 32'(out_valid), 0);
      check("rr_data", 32'(data_out), 0);
      check("rr_busy", 32'(busy), 0);
      check("rr_cfg_err", 32'(cfg_err), 0);
      @(negedge clk);
      rst = 1'b0; reflesh = 1'b0;
      nv = 0; nb = 0;
      for (int k = 0; k < 30; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (out_valid) nv++;
         if (busy) nb++;
      end
      check("rr_idle_valid", nv, 0);
      check("rr_idle_busy", nb, 0);

      run_frame(1024, 3, 1'b1, 4300);
      check("wide_first", first_lbl, 1028 + 1);
      check("wide_nvalid", n_valid, 3072);
      check("wide_nonzero", n_valid - n_zero, 1022);
      check("wide_neof", n_eof, 1);
      check("wide_eof_lbl", eof_lbl, 1028 + 3071 + 1);
      check("wide_data", data_bad, 0);
      check("wide_eol", eol_bad + eof_bad, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
